biriscv_mule_sched: RTL and testbench

Scheduler and sequencer for the shared multi-cycle execute unit (MULE) in the dual-issue core. It arbitrates MULE requests from issue pipe 0 and issue pipe 1, captures operands, and issues a one-cycle start pulse to the unit. It then tracks completion with a timeout watchdog and returns the result to the owning pipe. The exec stage consumes the result through its `mule_complete_i` / `mule_result_i` writeback override.

---
 rtl/biriscv_mule_sched.sv | 146 ++++++++++++++
 tb/tb_biriscv_mule_sched.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_mule_sched.sv
// Scheduler for the shared multi-cycle execute unit: arbitrates the two issue
// pipes, launches one operation at a time, watches for completion or timeout.
module biriscv_mule_sched #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        pipe0_valid_i,
    input  logic [31:0] pipe0_opcode_i,
    input  logic [31:0] pipe0_ra_operand_i,
    input  logic [31:0] pipe0_rb_operand_i,
    input  logic [4:0]  pipe0_rd_idx_i,
    input  logic        pipe1_valid_i,
    input  logic [31:0] pipe1_opcode_i,
    input  logic [31:0] pipe1_ra_operand_i,
    input  logic [31:0] pipe1_rb_operand_i,
    input  logic [4:0]  pipe1_rd_idx_i,
    output logic        pipe0_accept_o,
    output logic        pipe1_accept_o,
    output logic        hold_o,
    output logic        mule_start_o,
    output logic [31:0] mule_opcode_o,
    output logic [31:0] mule_ra_o,
    output logic [31:0] mule_rb_o,
    input  logic        mule_complete_i,
    input  logic [31:0] mule_result_i,
    output logic        wb_valid_o,
    output logic        wb_pipe_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        w_idle;
    logic        w_accept0;
    logic        w_accept1;
    logic        w_busy;
    logic        w_expired;
    logic [31:0] r_opcode;
    logic [31:0] r_ra;
    logic [31:0] r_rb;
    logic [4:0]  r_rd;
    logic        r_owner;
    logic [31:0] r_result;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    // The watchdog compares the value the counter is about to take, so the
    // ISSUE cycle counts as the first of the TIMEOUT_CYCLES.
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_expired = (w_cnt_inc == TO_LAST);
    assign w_accept0 = ~rst_i & ~flush_i & w_idle & pipe0_valid_i;
    assign w_accept1 = ~rst_i & ~flush_i & w_idle & ~pipe0_valid_i & pipe1_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept0 | w_accept1) w_state_next = ST_ISSUE;
                ST_ISSUE: w_state_next = mule_complete_i ? ST_RESP : ST_WAIT;
                ST_WAIT: begin
                    if (mule_complete_i)  w_state_next = ST_RESP;
                    else if (w_expired)   w_state_next = ST_IDLE;
                end
                ST_RESP:  w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Strobes decode the registered state; flush masks them in its own cycle.
    always_comb begin
        pipe0_accept_o = w_accept0;
        pipe1_accept_o = w_accept1;
        hold_o         = ~rst_i & (~w_idle | (pipe0_valid_i & pipe1_valid_i));
        mule_start_o   = ~flush_i & (r_state == ST_ISSUE);
        wb_valid_o     = ~flush_i & (r_state == ST_RESP);
        timeout_o      = ~flush_i & ~mule_complete_i & (r_state == ST_WAIT) & w_expired;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_opcode <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept0) begin
                r_opcode <= pipe0_opcode_i;
                r_ra     <= pipe0_ra_operand_i;
                r_rb     <= pipe0_rb_operand_i;
                r_rd     <= pipe0_rd_idx_i;
                r_owner  <= 1'b0;
            end else if (w_accept1) begin
                r_opcode <= pipe1_opcode_i;
                r_ra     <= pipe1_ra_operand_i;
                r_rb     <= pipe1_rb_operand_i;
                r_rd     <= pipe1_rd_idx_i;
                r_owner  <= 1'b1;
            end
            if (w_busy & mule_complete_i & ~flush_i) begin
                r_result <= mule_result_i;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign mule_opcode_o = r_opcode;
    assign mule_ra_o     = r_ra;
    assign mule_rb_o     = r_rb;
    assign wb_pipe_o     = r_owner;
    assign wb_rd_idx_o   = r_rd;
    assign wb_value_o    = r_result;

endmodule

// File: tb/tb_biriscv_mule_sched.sv
// Bench for biriscv_mule_sched: scenario tasks plus a writeback scoreboard.
module tb_biriscv_mule_sched;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        pipe0_valid_i;
    logic [31:0] pipe0_opcode_i;
    logic [31:0] pipe0_ra_operand_i;
    logic [31:0] pipe0_rb_operand_i;
    logic [4:0]  pipe0_rd_idx_i;
    logic        pipe1_valid_i;
    logic [31:0] pipe1_opcode_i;
    logic [31:0] pipe1_ra_operand_i;
    logic [31:0] pipe1_rb_operand_i;
    logic [4:0]  pipe1_rd_idx_i;
    logic        pipe0_accept_o;
    logic        pipe1_accept_o;
    logic        hold_o;
    logic        mule_start_o;
    logic [31:0] mule_opcode_o;
    logic [31:0] mule_ra_o;
    logic [31:0] mule_rb_o;
    logic        mule_complete_i;
    logic [31:0] mule_result_i;
    logic        wb_valid_o;
    logic        wb_pipe_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_value_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        pipe;
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;

    always #5 clk = ~clk;

    biriscv_mule_sched #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .pipe0_valid_i      (pipe0_valid_i),
        .pipe0_opcode_i     (pipe0_opcode_i),
        .pipe0_ra_operand_i (pipe0_ra_operand_i),
        .pipe0_rb_operand_i (pipe0_rb_operand_i),
        .pipe0_rd_idx_i     (pipe0_rd_idx_i),
        .pipe1_valid_i      (pipe1_valid_i),
        .pipe1_opcode_i     (pipe1_opcode_i),
        .pipe1_ra_operand_i (pipe1_ra_operand_i),
        .pipe1_rb_operand_i (pipe1_rb_operand_i),
        .pipe1_rd_idx_i     (pipe1_rd_idx_i),
        .pipe0_accept_o     (pipe0_accept_o),
        .pipe1_accept_o     (pipe1_accept_o),
        .hold_o             (hold_o),
        .mule_start_o       (mule_start_o),
        .mule_opcode_o      (mule_opcode_o),
        .mule_ra_o          (mule_ra_o),
        .mule_rb_o          (mule_rb_o),
        .mule_complete_i    (mule_complete_i),
        .mule_result_i      (mule_result_i),
        .wb_valid_o         (wb_valid_o),
        .wb_pipe_o          (wb_pipe_o),
        .wb_rd_idx_o        (wb_rd_idx_o),
        .wb_value_o         (wb_value_o),
        .timeout_o          (timeout_o)
    );

    // Scoreboard: every writeback must match the oldest expected entry.
    always @(negedge clk) begin
        if (wb_valid_o) begin
            total++;
            $display("wb: pipe=%0d rd=%0d value=%h", wb_pipe_o, wb_rd_idx_o, wb_value_o);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got pipe=%0d rd=%0d value=%h, required no writeback",
                         wb_pipe_o, wb_rd_idx_o, wb_value_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wb_pipe_o, wb_rd_idx_o, wb_value_o} !== mon_e) begin
                    bad++;
                    $display("FAIL wb_data: got pipe=%0d rd=%0d value=%h, required pipe=%0d rd=%0d value=%h",
                             wb_pipe_o, wb_rd_idx_o, wb_value_o, mon_e.pipe, mon_e.rd, mon_e.val);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_p0(input logic v, input logic [31:0] op, input logic [31:0] ra,
                            input logic [31:0] rb, input logic [4:0] rd);
        pipe0_valid_i = v; pipe0_opcode_i = op; pipe0_ra_operand_i = ra;
        pipe0_rb_operand_i = rb; pipe0_rd_idx_i = rd;
    endtask

    task automatic drive_p1(input logic v, input logic [31:0] op, input logic [31:0] ra,
                            input logic [31:0] rb, input logic [4:0] rd);
        pipe1_valid_i = v; pipe1_opcode_i = op; pipe1_ra_operand_i = ra;
        pipe1_rb_operand_i = rb; pipe1_rd_idx_i = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; mule_complete_i = 1'b0; mule_result_i = '0;
        drive_p0(1'b1, 32'h1, 32'h2, 32'h3, 5'd1);
        drive_p1(1'b1, 32'h4, 32'h5, 32'h6, 5'd2);
        repeat (2) @(negedge clk);
        total++;
        if ({pipe0_accept_o, pipe1_accept_o, hold_o, mule_start_o, wb_valid_o, timeout_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes: got acc0=%b acc1=%b hold=%b start=%b wb=%b to=%b, required all 0",
                     pipe0_accept_o, pipe1_accept_o, hold_o, mule_start_o, wb_valid_o, timeout_o);
        end
        total++;
        if ({mule_opcode_o, mule_ra_o, mule_rb_o, wb_pipe_o, wb_rd_idx_o, wb_value_o} !== '0) begin
            bad++;
            $display("FAIL reset_data: got op=%h ra=%h rb=%h pipe=%b rd=%0d val=%h, required all 0",
                     mule_opcode_o, mule_ra_o, mule_rb_o, wb_pipe_o, wb_rd_idx_o, wb_value_o);
        end
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        drive_p1(1'b0, '0, '0, '0, '0);
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if ({hold_o, mule_start_o, wb_valid_o} !== 3'b0) begin
            bad++;
            $display("FAIL reset_release: got hold=%b start=%b wb=%b, required 0 0 0",
                     hold_o, mule_start_o, wb_valid_o);
        end
    endtask

    task automatic test_single_op();
        next_cycle();
        drive_p0(1'b1, 32'h02B50533, 32'd7, 32'd6, 5'd10);
        exp_q.push_back(wb_t'{1'b0, 5'd10, 32'd42});
        @(negedge clk);
        total++;
        if ({pipe0_accept_o, pipe1_accept_o, hold_o} !== 3'b100) begin
            bad++;
            $display("FAIL single_accept: got acc0/acc1/hold=%b, required 100",
                     {pipe0_accept_o, pipe1_accept_o, hold_o});
        end
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++;
        if ({mule_start_o, hold_o} !== 2'b11) begin
            bad++;
            $display("FAIL single_start: got start/hold=%b, required 11", {mule_start_o, hold_o});
        end
        total++;
        if ({mule_opcode_o, mule_ra_o, mule_rb_o} !== {32'h02B50533, 32'd7, 32'd6}) begin
            bad++;
            $display("FAIL single_operands: got op=%h ra=%h rb=%h, required 02b50533 7 6",
                     mule_opcode_o, mule_ra_o, mule_rb_o);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({mule_start_o, hold_o, mule_opcode_o} !== {2'b01, 32'h02B50533}) begin
            bad++;
            $display("FAIL single_wait: got start=%b hold=%b op=%h, required 0 1 02b50533",
                     mule_start_o, hold_o, mule_opcode_o);
        end
        next_cycle();
        mule_complete_i = 1'b1; mule_result_i = 32'd42;
        @(negedge clk);
        total++;
        if ({hold_o, wb_valid_o} !== 2'b10) begin
            bad++;
            $display("FAIL single_complete: got hold/wb=%b, required 10", {hold_o, wb_valid_o});
        end
        next_cycle();
        mule_complete_i = 1'b0; mule_result_i = '0;
        @(negedge clk);
        total++;
        if ({wb_valid_o, hold_o} !== 2'b11) begin
            bad++;
            $display("FAIL single_wb: got wb/hold=%b, required 11", {wb_valid_o, hold_o});
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({wb_valid_o, hold_o} !== 2'b00) begin
            bad++;
            $display("FAIL single_idle: got wb/hold=%b, required 00", {wb_valid_o, hold_o});
        end
    endtask

    task automatic test_dual_request();
        next_cycle();
        drive_p0(1'b1, 32'hAAAA0001, 32'd3, 32'd4, 5'd5);
        drive_p1(1'b1, 32'hBBBB0002, 32'd11, 32'd12, 5'd6);
        exp_q.push_back(wb_t'{1'b0, 5'd5, 32'd100});
        @(negedge clk);
        total++;
        if ({pipe0_accept_o, pipe1_accept_o, hold_o} !== 3'b101) begin
            bad++;
            $display("FAIL dual_arb: got acc0/acc1/hold=%b, required 101",
                     {pipe0_accept_o, pipe1_accept_o, hold_o});
        end
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++;
        if ({mule_start_o, pipe1_accept_o, hold_o, mule_ra_o} !== {3'b101, 32'd3}) begin
            bad++;
            $display("FAIL dual_issue0: got start=%b acc1=%b hold=%b ra=%0d, required 1 0 1 3",
                     mule_start_o, pipe1_accept_o, hold_o, mule_ra_o);
        end
        next_cycle();
        mule_complete_i = 1'b1; mule_result_i = 32'd100;
        @(negedge clk);
        next_cycle();
        mule_complete_i = 1'b0;
        @(negedge clk);
        total++;
        if ({wb_valid_o, pipe1_accept_o, hold_o} !== 3'b101) begin
            bad++;
            $display("FAIL dual_resp0: got wb/acc1/hold=%b, required 101",
                     {wb_valid_o, pipe1_accept_o, hold_o});
        end
        next_cycle();
        exp_q.push_back(wb_t'{1'b1, 5'd6, 32'd200});
        @(negedge clk);
        total++;
        if ({pipe0_accept_o, pipe1_accept_o, hold_o} !== 3'b010) begin
            bad++;
            $display("FAIL dual_accept1: got acc0/acc1/hold=%b, required 010",
                     {pipe0_accept_o, pipe1_accept_o, hold_o});
        end
        next_cycle();
        drive_p1(1'b0, '0, '0, '0, '0);
        mule_complete_i = 1'b1; mule_result_i = 32'd200;
        @(negedge clk);
        total++;
        if ({mule_start_o, mule_opcode_o, mule_ra_o, mule_rb_o} !== {1'b1, 32'hBBBB0002, 32'd11, 32'd12}) begin
            bad++;
            $display("FAIL dual_issue1: got start=%b op=%h ra=%0d rb=%0d, required 1 bbbb0002 11 12",
                     mule_start_o, mule_opcode_o, mule_ra_o, mule_rb_o);
        end
        next_cycle();
        mule_complete_i = 1'b0;
        @(negedge clk);
        total++;
        if (wb_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL dual_wb1: got wb=%b, required 1", wb_valid_o);
        end
    endtask

    task automatic test_zero_wait();
        next_cycle();
        drive_p0(1'b1, 32'h12345678, 32'd1, 32'd2, 5'd1);
        exp_q.push_back(wb_t'{1'b0, 5'd1, 32'hDEADBEEF});
        @(negedge clk);
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        mule_complete_i = 1'b1; mule_result_i = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (mule_start_o !== 1'b1) begin
            bad++;
            $display("FAIL zw_start: got start=%b, required 1", mule_start_o);
        end
        next_cycle();
        mule_complete_i = 1'b0; mule_result_i = '0;
        @(negedge clk);
        total++;
        if ({wb_valid_o, timeout_o} !== 2'b10) begin
            bad++;
            $display("FAIL zw_wb: got wb/timeout=%b, required 10", {wb_valid_o, timeout_o});
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (hold_o !== 1'b0) begin
            bad++;
            $display("FAIL zw_idle: got hold=%b, required 0", hold_o);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        drive_p0(1'b1, 32'h0000CAFE, 32'd9, 32'd9, 5'd2);
        @(negedge clk);
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (timeout_o !== 1'b0) begin
                bad++;
                $display("FAIL to_early: cycle %0d got timeout=%b, required 0", c, timeout_o);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if ({timeout_o, wb_valid_o, hold_o} !== 3'b101) begin
            bad++;
            $display("FAIL to_fire: got timeout/wb/hold=%b, required 101", {timeout_o, wb_valid_o, hold_o});
        end
        next_cycle();
        drive_p0(1'b1, 32'h0000F00D, 32'd1, 32'd1, 5'd3);
        exp_q.push_back(wb_t'{1'b0, 5'd3, 32'h55});
        @(negedge clk);
        total++;
        if ({timeout_o, pipe0_accept_o} !== 2'b01) begin
            bad++;
            $display("FAIL to_idle: got timeout/acc0=%b, required 01", {timeout_o, pipe0_accept_o});
        end
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        next_cycle();
        next_cycle();
        next_cycle();
        mule_complete_i = 1'b1; mule_result_i = 32'h55;
        @(negedge clk);
        total++;
        if ({timeout_o, hold_o} !== 2'b01) begin
            bad++;
            $display("FAIL to_race: got timeout/hold=%b, required 01", {timeout_o, hold_o});
        end
        next_cycle();
        mule_complete_i = 1'b0; mule_result_i = '0;
        @(negedge clk);
        total++;
        if ({wb_valid_o, timeout_o} !== 2'b10) begin
            bad++;
            $display("FAIL to_race_wb: got wb/timeout=%b, required 10", {wb_valid_o, timeout_o});
        end
    endtask

    task automatic test_flush();
        next_cycle();
        drive_p0(1'b1, 32'h0000AB00, 32'd4, 32'd4, 5'd4);
        @(negedge clk);
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        next_cycle();
        next_cycle();
        flush_i = 1'b1; mule_complete_i = 1'b1; mule_result_i = 32'h77;
        @(negedge clk);
        total++;
        if ({wb_valid_o, timeout_o, mule_start_o} !== 3'b000) begin
            bad++;
            $display("FAIL flush_cycle: got wb/timeout/start=%b, required 000",
                     {wb_valid_o, timeout_o, mule_start_o});
        end
        next_cycle();
        flush_i = 1'b0; mule_complete_i = 1'b0;
        @(negedge clk);
        total++;
        if ({hold_o, wb_valid_o} !== 2'b00) begin
            bad++;
            $display("FAIL flush_idle: got hold/wb=%b, required 00", {hold_o, wb_valid_o});
        end
        next_cycle();
        mule_complete_i = 1'b1; mule_result_i = 32'h88;
        @(negedge clk);
        next_cycle();
        mule_complete_i = 1'b0;
        flush_i = 1'b1;
        drive_p1(1'b1, 32'h0000CD00, 32'd21, 32'd22, 5'd9);
        @(negedge clk);
        total++;
        if ({pipe1_accept_o, wb_valid_o} !== 2'b00) begin
            bad++;
            $display("FAIL flush_gate: got acc1/wb=%b, required 00", {pipe1_accept_o, wb_valid_o});
        end
        next_cycle();
        flush_i = 1'b0;
        exp_q.push_back(wb_t'{1'b1, 5'd9, 32'h99});
        @(negedge clk);
        total++;
        if (pipe1_accept_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_new_acc: got acc1=%b, required 1", pipe1_accept_o);
        end
        next_cycle();
        drive_p1(1'b0, '0, '0, '0, '0);
        mule_complete_i = 1'b1; mule_result_i = 32'h99;
        @(negedge clk);
        total++;
        if ({mule_start_o, mule_ra_o} !== {1'b1, 32'd21}) begin
            bad++;
            $display("FAIL flush_new_start: got start=%b ra=%0d, required 1 21", mule_start_o, mule_ra_o);
        end
        next_cycle();
        mule_complete_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        next_cycle();
        drive_p0(1'b1, 32'h0000EE00, 32'd8, 32'd8, 5'd8);
        @(negedge clk);
        next_cycle();
        drive_p0(1'b0, '0, '0, '0, '0);
        next_cycle();
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if ({hold_o, mule_start_o, wb_valid_o, timeout_o, mule_opcode_o, mule_ra_o, wb_value_o} !== '0) begin
            bad++;
            $display("FAIL rst_async: got hold=%b start=%b wb=%b to=%b op=%h ra=%h val=%h, required all 0",
                     hold_o, mule_start_o, wb_valid_o, timeout_o, mule_opcode_o, mule_ra_o, wb_value_o);
        end
        mule_complete_i = 1'b1; mule_result_i = 32'h66;
        next_cycle();
        mule_complete_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if ({hold_o, wb_valid_o, timeout_o} !== 3'b000) begin
            bad++;
            $display("FAIL rst_after: got hold/wb/to=%b, required 000", {hold_o, wb_valid_o, timeout_o});
        end
        test_single_op();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_dual_request();
        test_zero_wait();
        test_timeout();
        test_flush();
        test_reset_mid_op();
        next_cycle();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending writebacks, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
